// File: rtl/qenc_cqp_if.sv
// Bin stream from the chroma QP offset sub-FSM to the CABAC arithmetic encoding engine.
// The master presents context-coded bins; the engine accepts a bin when vld && rdy.
interface qenc_cqp_if #(
  parameter int CTX_AW = 10
);
  logic              enc_bin;
  logic [CTX_AW-1:0] enc_ctx_addr;
  logic              enc_bin_vld;
  logic              enc_rdy;
  logic              EPMode_cqp;

  modport master (
    output enc_bin,
    output enc_ctx_addr,
    output enc_bin_vld,
    output EPMode_cqp,
    input  enc_rdy
  );

  modport slave (
    input  enc_bin,
    input  enc_ctx_addr,
    input  enc_bin_vld,
    input  EPMode_cqp,
    output enc_rdy
  );
endinterface

// File: rtl/qenc_cqp_fsm.sv
// Encoder sub-FSM for the CU chroma QP offset syntax: it binarises the flag and the TR-coded idx
// and streams them as regular context-coded bins, then pulses done to the CU-level FSM.
module qenc_cqp_fsm #(
  parameter int                CTX_AW        = 10,
  parameter logic [CTX_AW-1:0] CTX_FLAG_ADDR = CTX_AW'(200),
  parameter logic [CTX_AW-1:0] CTX_IDX_ADDR  = CTX_AW'(201)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cqp_start,
  input  logic       cu_chroma_qp_offset_enabled_flag,
  input  logic [2:0] chroma_qp_offset_list_len,
  input  logic       cu_chroma_qp_offset_flag,
  input  logic [2:0] cu_chroma_qp_offset_idx,
  qenc_cqp_if.master enc,
  output logic       cqp_busy,
  output logic       cqp_idx_clip,
  output logic       cqp_done_intr
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FLAG   = 2'd1,
    IDX    = 2'd2,
    ENDING = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic              flag_q, flag_d;
  logic [2:0]        idx_q, idx_d;
  logic [2:0]        len_q, len_d;
  logic [2:0]        cnt_q, cnt_d;
  logic              vld_q, vld_d;
  logic              bin_q, bin_d;
  logic [CTX_AW-1:0] addr_q, addr_d;
  logic              busy_q, busy_d;
  logic              clip_q, clip_d;
  logic              done_q, done_d;

  logic [2:0]        idx_eff;
  logic [3:0]        idx_bins;
  logic [3:0]        cnt_inc;
  logic              xfer;

  // idx is clipped to cMax before truncated-rice binarisation
  function automatic logic [2:0] sat_idx(input logic [2:0] idx, input logic [2:0] cmax);
    return (idx > cmax) ? cmax : idx;
  endfunction

  // TR with cRiceParam=0: bin at position pos is 1 while pos < value, then a single 0
  function automatic logic tr_bin(input logic [2:0] pos, input logic [2:0] value);
    return (pos < value);
  endfunction

  assign idx_eff  = sat_idx(idx_q, len_q);
  assign idx_bins = {1'b0, idx_eff} + {3'b000, (idx_eff < len_q)};
  assign cnt_inc  = {1'b0, cnt_q} + 4'd1;
  assign xfer     = vld_q && enc.enc_rdy;

  always_comb begin
    state_d = state_q;
    flag_d  = flag_q;
    idx_d   = idx_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    vld_d   = vld_q;
    bin_d   = bin_q;
    addr_d  = addr_q;
    busy_d  = busy_q;
    clip_d  = clip_q;
    done_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        vld_d = 1'b0;
        if (cqp_start) begin
          flag_d = cu_chroma_qp_offset_flag;
          idx_d  = cu_chroma_qp_offset_idx;
          len_d  = chroma_qp_offset_list_len;
          cnt_d  = 3'd0;
          busy_d = 1'b1;
          clip_d = 1'b0;
          if (cu_chroma_qp_offset_enabled_flag) begin
            state_d = FLAG;
            vld_d   = 1'b1;
            bin_d   = cu_chroma_qp_offset_flag;
            addr_d  = CTX_FLAG_ADDR;
          end else begin
            state_d = ENDING;
          end
        end
      end

      FLAG: begin
        if (xfer) begin
          if (flag_q && (len_q != 3'd0)) begin
            state_d = IDX;
            cnt_d   = 3'd0;
            vld_d   = 1'b1;
            bin_d   = tr_bin(3'd0, idx_eff);
            addr_d  = CTX_IDX_ADDR;
            clip_d  = (idx_q > len_q);
          end else begin
            state_d = ENDING;
            vld_d   = 1'b0;
          end
        end
      end

      IDX: begin
        if (xfer) begin
          cnt_d = cnt_inc[2:0];
          // the bin just accepted was the last one of the TR string
          if (cnt_inc == idx_bins) begin
            state_d = ENDING;
            vld_d   = 1'b0;
          end else begin
            bin_d = tr_bin(cnt_inc[2:0], idx_eff);
          end
        end
      end

      ENDING: begin
        state_d = IDLE;
        vld_d   = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end

      default: begin
        state_d = IDLE;
        vld_d   = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      flag_q  <= 1'b0;
      idx_q   <= 3'd0;
      len_q   <= 3'd0;
      cnt_q   <= 3'd0;
      vld_q   <= 1'b0;
      bin_q   <= 1'b0;
      addr_q  <= '0;
      busy_q  <= 1'b0;
      clip_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      flag_q  <= flag_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      vld_q   <= vld_d;
      bin_q   <= bin_d;
      addr_q  <= addr_d;
      busy_q  <= busy_d;
      clip_q  <= clip_d;
      done_q  <= done_d;
    end
  end

  assign enc.enc_bin      = bin_q;
  assign enc.enc_ctx_addr = addr_q;
  assign enc.enc_bin_vld  = vld_q;
  assign enc.EPMode_cqp   = 1'b0;
  assign cqp_busy         = busy_q;
  assign cqp_idx_clip     = clip_q;
  assign cqp_done_intr    = done_q;

endmodule
